// File: rtl/clk_sel_pkg.sv
// Shared state type and default parameter values for clk_source_switcher.
package clk_sel_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        DRAIN  = 2'd1,
        ARM    = 2'd2
    } state_t;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SWITCH_TIMEOUT = 1023;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous level; all stages reset to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/clk_source_switcher.sv
// Glitch-free selector for slow fabric clocks, fully synchronous to clk.
// Define CLK_SEL_TIMEOUT_EN to add the forced-switch timeout counter and timeout_flag.
module clk_source_switcher
    import clk_sel_pkg::*;
#(
    parameter int  N_CH           = DEF_N_CH,
    parameter int  SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int  SWITCH_TIMEOUT = DEF_SWITCH_TIMEOUT,
    localparam int SEL_W          = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  src_in,
    input  logic [SEL_W-1:0] sel,
    output logic             out_level,
    output logic             out_tick,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             sel_err,
    output logic             timeout_flag
);

    localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0]  s_src;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pend_sel;
    state_t           state;
    logic             src_cur;
    logic             src_pend;
    logic             sel_bad;
    logic             done_sw;
    logic             force_sw;
    logic             level_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_sync
        bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (src_in[i]),
            .q     (s_src[i])
        );
    end

    always_comb begin
        src_cur   = s_src[cur_sel];
        src_pend  = s_src[pend_sel];
        sel_bad   = ({1'b0, sel_q} >= N_CH_V);
        done_sw   = (state == ARM) && !src_pend;
        // Once draining has seen the old source low, the output is held low until lock.
        level_nxt = (state == ARM) ? 1'b0 : src_cur;
    end

`ifdef CLK_SEL_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(SWITCH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SWITCH_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the cycle that would be the SWITCH_TIMEOUT-th spent in DRAIN/ARM.
    assign force_sw = (state != LOCKED) && (tmo_cnt == TMO_LAST) && !done_sw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            tmo_cnt <= (state == LOCKED) ? '0 : tmo_cnt + 1'b1;
            if (force_sw) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (SWITCH_TIMEOUT != 0);
    assign force_sw       = 1'b0;
    assign timeout_flag   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKED;
            sel_q     <= '0;
            pend_sel  <= '0;
            cur_sel   <= '0;
            busy      <= 1'b0;
            sel_err   <= 1'b0;
            out_level <= 1'b0;
            out_tick  <= 1'b0;
        end else begin
            sel_q     <= sel;
            sel_err   <= sel_bad;
            out_level <= level_nxt;
            out_tick  <= level_nxt & ~out_level;
            case (state)
                LOCKED: begin
                    if ((sel_q != cur_sel) && !sel_bad) begin
                        pend_sel <= sel_q;
                        state    <= DRAIN;
                        busy     <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!src_cur) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (done_sw) begin
                        cur_sel <= pend_sel;
                        state   <= LOCKED;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= LOCKED;
                    busy  <= 1'b0;
                end
            endcase
            if (force_sw) begin
                cur_sel <= pend_sel;
                state   <= LOCKED;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_source_switcher.sv
// Bench for clk_source_switcher: cycle model feeding an expectation queue, plus directed scenarios.
module tb_clk_source_switcher;

    localparam int N_CH = 4;
    localparam int TMO  = 15;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] src_in = '0;
    logic [1:0] sel    = '0;
    logic       out_level;
    logic       out_tick;
    logic [1:0] cur_sel;
    logic       busy;
    logic       sel_err;
    logic       timeout_flag;

    clk_source_switcher #(
        .N_CH           (N_CH),
        .SYNC_STAGES    (2),
        .SWITCH_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_in       (src_in),
        .sel          (sel),
        .out_level    (out_level),
        .out_tick     (out_tick),
        .cur_sel      (cur_sel),
        .busy         (busy),
        .sel_err      (sel_err),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source generator: each channel is periodic unless forced to a level.
    int   per     [4] = '{8, 6, 20, 10};
    logic frc_en  [4] = '{default: 1'b0};
    logic frc_val [4] = '{default: 1'b0};
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            src_in[c] = frc_en[c] ? frc_val[c] : ((cyc % per[c]) < (per[c] / 2));
        end
    end

    // Reference model: predicts the outputs after the next rising edge.
    typedef struct packed {
        logic       lvl;
        logic       tick;
        logic [1:0] cur;
        logic       busy;
        logic       err;
        logic       flag;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       sb_e;
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [1:0] m_selq = '0;
    logic [1:0] m_cur = '0;
    logic [1:0] m_pend = '0;
    int         m_state = 0;
    int         m_cnt = 0;
    logic       m_lvl = 1'b0;
    logic       m_flag = 1'b0;

    task automatic model_step();
        logic       cur_hi;
        logic       pend_hi;
        logic       n_lvl;
        logic       n_flag;
        logic [1:0] n_cur;
        logic [1:0] n_pend;
        int         n_state;
        int         n_cnt;
        exp_t       e;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_selq = '0; m_cur = '0; m_pend = '0;
            m_state = 0; m_cnt = 0; m_lvl = 1'b0; m_flag = 1'b0;
            exp_q.push_back('0);
            return;
        end
        cur_hi  = m_s2[m_cur];
        pend_hi = m_s2[m_pend];
        n_lvl   = (m_state == 2) ? 1'b0 : cur_hi;
        n_state = m_state;
        n_cur   = m_cur;
        n_pend  = m_pend;
        n_flag  = m_flag;
        n_cnt   = (m_state == 0) ? 0 : m_cnt + 1;
        case (m_state)
            0: if (m_selq != m_cur && int'(m_selq) < N_CH) begin n_pend = m_selq; n_state = 1; end
            1: if (!cur_hi) n_state = 2;
            2: if (!pend_hi) begin n_cur = m_pend; n_state = 0; end
            default: n_state = 0;
        endcase
`ifdef CLK_SEL_TIMEOUT_EN
        if (m_state != 0 && n_state != 0 && n_cnt == TMO) begin
            n_cur = m_pend; n_state = 0; n_flag = 1'b1;
        end
`endif
        e.lvl  = n_lvl;
        e.tick = n_lvl & ~m_lvl;
        e.cur  = n_cur;
        e.busy = (n_state != 0);
        e.err  = (int'(m_selq) >= N_CH);
        e.flag = n_flag;
        exp_q.push_back(e);
        m_s2 = m_s1; m_s1 = src_in; m_selq = sel;
        m_state = n_state; m_cur = n_cur; m_pend = n_pend; m_cnt = n_cnt;
        m_lvl = n_lvl; m_flag = n_flag;
    endtask

    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            if (!rst_n) sb_e = '0;
            check("sb_out_level", int'(out_level), int'(sb_e.lvl));
            check("sb_out_tick", int'(out_tick), int'(sb_e.tick));
            check("sb_cur_sel", int'(cur_sel), int'(sb_e.cur));
            check("sb_busy", int'(busy), int'(sb_e.busy));
            check("sb_sel_err", int'(sel_err), int'(sb_e.err));
            check("sb_timeout_flag", int'(timeout_flag), int'(sb_e.flag));
        end
        model_step();
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_busy(input string tag, input logic val, input int limit, output int n);
        n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== val) check({tag, "_bound"}, int'(busy), int'(val));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        sel   = 2'd0;
        tick_n(10);
        check("rst_out_level", int'(out_level), 0);
        check("rst_out_tick", int'(out_tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cur_sel", int'(cur_sel), 0);
        check("rst_timeout_flag", int'(timeout_flag), 0);
        rst_n = 1'b1;

        // Source edge to out_level latency
        frc_en[0] = 1'b1; frc_val[0] = 1'b0;
        tick_n(6);
        frc_val[0] = 1'b1;
        @(posedge clk);
        n = 0;
        while (!out_level && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("src_to_out_edges", n - 1, 3);
        tick_n(1);

        // Switch 0 -> 2 started while src0 is high
        frc_en[0] = 1'b0;
        tick_n(2);
        n = 0;
        while (src_in[0] !== 1'b1 && n < 20) begin
            tick_n(1);
            n++;
        end
        sel = 2'd2;
        wait_busy("sw02_rise", 1'b1, 10, n);
        check("sw02_busy_delay", n - 1, 2);
        wait_busy("sw02_done", 1'b0, 60, n);
        check("sw02_cur_sel", int'(cur_sel), 2);

        // Minimum switch with both sources already low
        frc_en[1] = 1'b1; frc_val[1] = 1'b0;
        frc_en[2] = 1'b1; frc_val[2] = 1'b0;
        tick_n(5);
        sel = 2'd1;
        wait_busy("both_rise", 1'b1, 10, n);
        wait_busy("both_done", 1'b0, 10, n);
        check("both_busy_len", n, 2);
        check("both_cur_sel", int'(cur_sel), 1);

        // sel change during DRAIN is deferred until after lock
        frc_val[1] = 1'b1;
        frc_en[3] = 1'b1; frc_val[3] = 1'b0;
        tick_n(5);
        sel = 2'd3;
        wait_busy("mid_rise", 1'b1, 10, n);
        tick_n(1);
        sel = 2'd1;
        tick_n(4);
        check("mid_drain_hold", int'(busy), 1);
        frc_val[1] = 1'b0;
        wait_busy("mid_done", 1'b0, 20, n);
        check("mid_cur_sel_first", int'(cur_sel), 3);
        wait_busy("mid_rise2", 1'b1, 10, n);
        check("mid_reswitch_gap", n, 1);
        wait_busy("mid_done2", 1'b0, 20, n);
        check("mid_cur_sel_second", int'(cur_sel), 1);

        // Old source stuck high
        frc_val[1] = 1'b1;
        tick_n(5);
        frc_en[0] = 1'b1; frc_val[0] = 1'b0;
        sel = 2'd0;
        wait_busy("tmo_rise", 1'b1, 10, n);
`ifdef CLK_SEL_TIMEOUT_EN
        wait_busy("tmo_done", 1'b0, 40, n);
        check("tmo_busy_len", n, TMO);
        check("tmo_flag", int'(timeout_flag), 1);
        check("tmo_cur_sel", int'(cur_sel), 0);
`else
        tick_n(40);
        check("stuck_busy", int'(busy), 1);
        check("stuck_flag", int'(timeout_flag), 0);
        check("stuck_cur_sel", int'(cur_sel), 1);
        rst_n = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(2);
        check("stuck_recover_cur_sel", int'(cur_sel), 0);
`endif

        // Reset while waiting in ARM
        frc_en[3] = 1'b1; frc_val[3] = 1'b1;
        tick_n(4);
        sel = 2'd3;
        wait_busy("arm_rise", 1'b1, 10, n);
        tick_n(3);
        check("arm_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arm_rst_busy", int'(busy), 0);
        check("arm_rst_cur_sel", int'(cur_sel), 0);
        check("arm_rst_out_level", int'(out_level), 0);
        check("arm_rst_timeout_flag", int'(timeout_flag), 0);
        tick_n(3);
        rst_n = 1'b1;

        // Free-running sources with random requests
        for (int c = 0; c < 4; c++) frc_en[c] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sel = 2'($urandom_range(0, 3));
            tick_n(int'($urandom_range(3, 12)));
        end
        tick_n(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
